matmul_sequencer: RTL and testbench

Sequences one matrix-multiply operation on the systolic datapath once a start command is issued with its control fields (mode, dimensions, reload flags). Generates operand-buffer read strobes, array enable/clear, drain timing and result-row write handshakes, then signals completion. Sits between the control-register block and the operand buffers / PE array; flags start-while-busy as an error.

---
 rtl/matmul_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequences one systolic matrix-multiply: clear, feed, drain, row write-back.
// Optional PERF_CNT_EN adds op_cycles_o, a saturating busy-cycle counter.
module matmul_sequencer #(
    parameter int DIM_W = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [DIM_W-1:0] dim_n_i,
    input  logic [DIM_W-1:0] dim_k_i,
    input  logic [DIM_W-1:0] dim_m_i,
    input  logic             reload_a_i,
    input  logic             reload_b_i,
    input  logic             res_wr_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             array_clr_o,
    output logic             array_en_o,
    output logic             a_rd_en_o,
    output logic             b_rd_en_o,
    output logic [DIM_W-1:0] k_idx_o,
    output logic             res_wr_en_o,
`ifdef PERF_CNT_EN
    output logic [DIM_W-1:0] res_row_o,
    output logic [15:0]      op_cycles_o
`else
    output logic [DIM_W-1:0] res_row_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_dim_n;
    logic [DIM_W-1:0] r_dim_k;
    logic [DIM_W-1:0] r_dim_m;
    logic             r_reload_a;
    logic             r_reload_b;
    logic             r_cached;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DIM_W-1:0] w_row_nxt;
    logic [DIM_W-1:0] w_dim_n_nxt;
    logic [DIM_W-1:0] w_dim_k_nxt;
    logic [DIM_W-1:0] w_dim_m_nxt;
    logic             w_reload_a_nxt;
    logic             w_reload_b_nxt;
    logic             w_cached_nxt;
    logic [CNT_W-1:0] w_drain_len;
    logic             w_feed_nxt;

    // Skew between the first and last PE of an N x M array is (N-1)+(M-1) steps.
    assign w_drain_len = CNT_W'(r_dim_n) + CNT_W'(r_dim_m);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_row_nxt      = r_row;
        w_dim_n_nxt    = r_dim_n;
        w_dim_k_nxt    = r_dim_k;
        w_dim_m_nxt    = r_dim_m;
        w_reload_a_nxt = r_reload_a;
        w_reload_b_nxt = r_reload_b;
        w_cached_nxt   = r_cached;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_dim_n_nxt    = dim_n_i;
                    w_dim_k_nxt    = dim_k_i;
                    w_dim_m_nxt    = dim_m_i;
                    w_reload_a_nxt = reload_a_i;
                    w_reload_b_nxt = reload_b_i;
                    w_cnt_nxt      = '0;
                    w_row_nxt      = '0;
                    w_state_nxt    = mode_i ? S_FEED : S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_FEED;
            end
            S_FEED: begin
                if (r_cnt == CNT_W'(r_dim_k)) begin
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = (w_drain_len == '0) ? S_WRITE : S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == w_drain_len - CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                // res_wr_en_o is high throughout WRITE, so ready alone completes the handshake.
                if (res_wr_ready_i) begin
                    if (r_row == r_dim_n) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_row_nxt = r_row + DIM_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_cached_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_feed_nxt = (w_state_nxt == S_FEED);

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_dim_n     <= '0;
            r_dim_k     <= '0;
            r_dim_m     <= '0;
            r_reload_a  <= 1'b0;
            r_reload_b  <= 1'b0;
            r_cached    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            array_clr_o <= 1'b0;
            array_en_o  <= 1'b0;
            a_rd_en_o   <= 1'b0;
            b_rd_en_o   <= 1'b0;
            k_idx_o     <= '0;
            res_wr_en_o <= 1'b0;
            res_row_o   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_dim_n     <= w_dim_n_nxt;
            r_dim_k     <= w_dim_k_nxt;
            r_dim_m     <= w_dim_m_nxt;
            r_reload_a  <= w_reload_a_nxt;
            r_reload_b  <= w_reload_b_nxt;
            r_cached    <= w_cached_nxt;
            busy_o      <= (w_state_nxt != S_IDLE);
            done_o      <= (w_state_nxt == S_DONE);
            err_o       <= start_i && (r_state != S_IDLE);
            array_clr_o <= (w_state_nxt == S_CLEAR);
            array_en_o  <= w_feed_nxt || (w_state_nxt == S_DRAIN);
            a_rd_en_o   <= w_feed_nxt && (w_reload_a_nxt || !w_cached_nxt);
            b_rd_en_o   <= w_feed_nxt && (w_reload_b_nxt || !w_cached_nxt);
            k_idx_o     <= w_feed_nxt ? w_cnt_nxt[DIM_W-1:0] : '0;
            res_wr_en_o <= (w_state_nxt == S_WRITE);
            res_row_o   <= (w_state_nxt == S_WRITE) ? w_row_nxt : '0;
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] r_op_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op_cycles <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_op_cycles <= '0;
        end else if (busy_o && (r_op_cycles != 16'hFFFF)) begin
            r_op_cycles <= r_op_cycles + 16'd1;
        end
    end

    assign op_cycles_o = r_op_cycles;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - table-driven scoreboard bench for matmul_sequencer.
module tb_matmul_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [1:0] dim_n_i = '0;
    logic [1:0] dim_k_i = '0;
    logic [1:0] dim_m_i = '0;
    logic       reload_a_i = 1'b0;
    logic       reload_b_i = 1'b0;
    logic       res_wr_ready_i = 1'b1;
    logic       busy_o, done_o, err_o, array_clr_o, array_en_o, a_rd_en_o, b_rd_en_o, res_wr_en_o;
    logic [1:0] k_idx_o, res_row_o;
`ifdef PERF_CNT_EN
    logic [15:0] op_cycles_o;
`endif

    matmul_sequencer #(.DIM_W(2), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
        .reload_a_i(reload_a_i), .reload_b_i(reload_b_i), .res_wr_ready_i(res_wr_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .array_clr_o(array_clr_o),
        .array_en_o(array_en_o), .a_rd_en_o(a_rd_en_o), .b_rd_en_o(b_rd_en_o),
        .k_idx_o(k_idx_o), .res_wr_en_o(res_wr_en_o),
`ifdef PERF_CNT_EN
        .res_row_o(res_row_o), .op_cycles_o(op_cycles_o)
`else
        .res_row_o(res_row_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit mode;
        int n, k, m;
        bit ra, rb;
        int stall_row, stall_cnt, err_at, exp_busy;
    } op_t;

    typedef struct {
        logic [11:0] v;
        bit          ready;
        bit          start;
    } ent_t;

    ent_t q[$];
    op_t  ops[6];
    int   checks = 0;
    int   errors = 0;
    bit   cached = 0;

    // {busy, done, err, clr, en, a, b, k[1:0], wr, row[1:0]}
    wire [11:0] dut_vec = {busy_o, done_o, err_o, array_clr_o, array_en_o, a_rd_en_o, b_rd_en_o,
                           k_idx_o, res_wr_en_o, res_row_o};

    function automatic logic [11:0] pk(bit busy, bit done, bit clr, bit en, bit a, bit b,
                                       int k, bit wr, int row);
        logic [1:0] kk = 2'(k);
        logic [1:0] rr = 2'(row);
        return {busy, done, 1'b0, clr, en, a, b, kk, wr, rr};
    endfunction

    task automatic push(input logic [11:0] v, input bit ready);
        ent_t e;
        e.v = v; e.ready = ready; e.start = 1'b0;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic build(input op_t o);
        bit   ea = o.ra || !cached;
        bit   eb = o.rb || !cached;
        ent_t t;
        if (!o.mode) push(pk(1, 0, 1, 0, 0, 0, 0, 0, 0), 1);
        for (int i = 0; i < o.k; i++) push(pk(1, 0, 0, 1, ea, eb, i, 0, 0), 1);
        for (int i = 0; i < o.n + o.m - 2; i++) push(pk(1, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        for (int r = 0; r < o.n; r++) begin
            if (r == o.stall_row)
                for (int s = 0; s < o.stall_cnt; s++) push(pk(1, 0, 0, 0, 0, 0, 0, 1, r), 0);
            push(pk(1, 0, 0, 0, 0, 0, 0, 1, r), 1);
        end
        push(pk(1, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        if (o.err_at >= 0) begin
            t = q[o.err_at]; t.start = 1'b1; q[o.err_at] = t;
            t = q[o.err_at + 1]; t.v[9] = 1'b1; q[o.err_at + 1] = t;
        end
    endtask

    // Entered and left on a falling edge; the final idle cycle is the earliest new-start slot.
    task automatic run_op(input op_t o, input int idx);
        ent_t e;
        int   busy_cnt = 0;
        build(o);
        mode_i = o.mode; dim_n_i = 2'(o.n - 1); dim_k_i = 2'(o.k - 1); dim_m_i = 2'(o.m - 1);
        reload_a_i = o.ra; reload_b_i = o.rb; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        mode_i = 1'($urandom); dim_n_i = 2'($urandom); dim_k_i = 2'($urandom);
        dim_m_i = 2'($urandom); reload_a_i = 1'($urandom); reload_b_i = 1'($urandom);
        while (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("trace op%0d", idx), 32'(dut_vec), 32'(e.v));
            if (busy_o) busy_cnt++;
            res_wr_ready_i = e.ready;
            start_i = e.start;
            if (q.size() > 0) @(negedge clk_i);
        end
        start_i = 1'b0;
        check($sformatf("busy_len op%0d", idx), 32'(busy_cnt), 32'(o.exp_busy));
`ifdef PERF_CNT_EN
        check($sformatf("op_cycles op%0d", idx), 32'(op_cycles_o), 32'(o.exp_busy));
`endif
        cached = 1'b1;
    endtask

    initial begin
        //          mode n  k  m  ra rb srow scnt err busy
        ops[0] = '{0,  4, 4, 4, 0, 0, -1, 0,  -1, 16};
        ops[1] = '{1,  1, 1, 1, 0, 1, -1, 0,  -1, 3};
        ops[2] = '{0,  4, 4, 4, 1, 1,  2, 3,  -1, 19};
        ops[3] = '{0,  4, 4, 4, 0, 0, -1, 0,   6, 16};
        ops[4] = '{1,  2, 3, 1, 1, 0, -1, 0,  -1, 7};
        ops[5] = '{0,  1, 4, 3, 0, 0, -1, 0,  -1, 9};

        #12;
        check("reset_outputs", 32'(dut_vec), 32'd0);
`ifdef PERF_CNT_EN
        check("reset_op_cycles", 32'(op_cycles_o), 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Async reset in the middle of FEED.
        mode_i = 1'b0; dim_n_i = 2'd3; dim_k_i = 2'd3; dim_m_i = 2'd3;
        reload_a_i = 1'b0; reload_b_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_feed_en", 32'(array_en_o), 32'd1);
        check("mid_feed_k", 32'(k_idx_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_vec), 32'd0);
        check("async_reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cached = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 6; i++) run_op(ops[i], i);

        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        check("idle_after_ops", 32'(dut_vec), 32'd0);
`ifdef PERF_CNT_EN
        check("op_cycles_hold", 32'(op_cycles_o), 32'(ops[5].exp_busy));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
